// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
// Shared definitions for the dual-master AHB arbiter: HTRANS encodings,
// the arbiter FSM state type, the master-index type and small helpers.
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Index of a master: 0 = instruction side, 1 = data side.
  typedef logic mst_idx_t;

  // A transfer is requested only by NONSEQ or SEQ; IDLE and BUSY carry none.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  // Round-robin choice between the two pending flags. On a tie the master
  // that was not granted last wins.
  function automatic mst_idx_t pick_grant(input logic     pend0,
                                          input logic     pend1,
                                          input mst_idx_t last);
    if (pend0 && pend1) return mst_idx_t'(~last);
    else if (pend1)     return mst_idx_t'(1'b1);
    else                return mst_idx_t'(1'b0);
  endfunction

endpackage

// File: rtl/ahb_req_capture.sv
// ---------------------------------------------------------------------------
// ahb_req_capture
// Per-master address-phase holding register plus pending flag. A request is
// latched when the master sees HREADY high with HSEL set and an active
// HTRANS; the flag clears when the arbiter completes that master's transfer.
// A capture on the completion edge wins over the clear, so a master can
// issue back-to-back transfers.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_hsel, i_htrans      master select and transfer type
//   i_haddr, i_hwrite,
//   i_hsize               master address-phase controls
//   i_hready              HREADY currently driven back to this master
//   i_done                this master's transfer completes this cycle
//   o_pend                request waiting / in flight
//   o_haddr, o_hwrite,
//   o_hsize               latched address-phase controls
// ---------------------------------------------------------------------------
module ahb_req_capture
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hsel,
  input  logic [1:0]        i_htrans,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic              i_hready,
  input  logic              i_done,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize
);

  logic              w_capture;
  logic              r_pend;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hsize;

  assign w_capture = i_hready && i_hsel && is_active(i_htrans);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend   <= 1'b0;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
    end else if (w_capture) begin
      r_pend   <= 1'b1;
      r_haddr  <= i_haddr;
      r_hwrite <= i_hwrite;
      r_hsize  <= i_hsize;
    end else if (i_done) begin
      r_pend   <= 1'b0;
    end
  end

  assign o_pend   = r_pend;
  assign o_haddr  = r_haddr;
  assign o_hwrite = r_hwrite;
  assign o_hsize  = r_hsize;

endmodule

// File: rtl/ahb_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_dual_master_arbiter
// Shares one AHB slave between an instruction master (M0) and a data master
// (M1). Each master's address phase is buffered in an ahb_req_capture
// instance; an IDLE/ADDR/DATA FSM replays the granted request to the slave
// and routes the data phase back. Ties are broken round-robin.
//
// Ports:
//   HCLK, HRESETn                       clock, async active-low reset
//   mX_HSEL/HADDR/HTRANS/HWRITE/HSIZE   master X address phase
//   mX_HWDATA                           master X write data
//   mX_HRDATA/HREADY/HRESP              response to master X
//   s_HSEL/HADDR/HTRANS/HWRITE/HSIZE    shared-slave address phase
//   s_HWDATA, s_HREADY                  shared-slave write data, bus HREADY
//   s_HRDATA/HREADYOUT/HRESP            shared-slave response
//   grant_o                             master owning the current transfer
// ---------------------------------------------------------------------------
module ahb_dual_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // master 0 (instruction)
  input  logic              m0_HSEL,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic [1:0]        m0_HTRANS,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic [DATA_W-1:0] m0_HRDATA,
  output logic              m0_HREADY,
  output logic              m0_HRESP,
  // master 1 (data)
  input  logic              m1_HSEL,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic [1:0]        m1_HTRANS,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic              m1_HREADY,
  output logic              m1_HRESP,
  // shared slave
  output logic              s_HSEL,
  output logic [ADDR_W-1:0] s_HADDR,
  output logic [1:0]        s_HTRANS,
  output logic              s_HWRITE,
  output logic [2:0]        s_HSIZE,
  output logic [DATA_W-1:0] s_HWDATA,
  output logic              s_HREADY,
  input  logic [DATA_W-1:0] s_HRDATA,
  input  logic              s_HREADYOUT,
  input  logic              s_HRESP,
  output logic              grant_o
);

  arb_state_t  r_state;
  mst_idx_t    r_grant;
  mst_idx_t    r_last_grant;

  logic              w_pend0, w_pend1;
  logic [ADDR_W-1:0] w_haddr0, w_haddr1;
  logic              w_hwrite0, w_hwrite1;
  logic [2:0]        w_hsize0, w_hsize1;
  logic              w_done0, w_done1;
  logic              w_other_pend;
  mst_idx_t          w_next_grant;
  logic              w_busy;

  assign w_done0 = (r_state == ST_DATA) && (r_grant == 1'b0) && s_HREADYOUT;
  assign w_done1 = (r_state == ST_DATA) && (r_grant == 1'b1) && s_HREADYOUT;

  // HREADY stalls a master only while its buffered request is outstanding.
  assign m0_HREADY = !w_pend0 || w_done0;
  assign m1_HREADY = !w_pend1 || w_done1;

  ahb_req_capture #(.ADDR_W(ADDR_W)) u_cap0 (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_hsel   (m0_HSEL),
    .i_htrans (m0_HTRANS),
    .i_haddr  (m0_HADDR),
    .i_hwrite (m0_HWRITE),
    .i_hsize  (m0_HSIZE),
    .i_hready (m0_HREADY),
    .i_done   (w_done0),
    .o_pend   (w_pend0),
    .o_haddr  (w_haddr0),
    .o_hwrite (w_hwrite0),
    .o_hsize  (w_hsize0)
  );

  ahb_req_capture #(.ADDR_W(ADDR_W)) u_cap1 (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_hsel   (m1_HSEL),
    .i_htrans (m1_HTRANS),
    .i_haddr  (m1_HADDR),
    .i_hwrite (m1_HWRITE),
    .i_hsize  (m1_HSIZE),
    .i_hready (m1_HREADY),
    .i_done   (w_done1),
    .o_pend   (w_pend1),
    .o_haddr  (w_haddr1),
    .o_hwrite (w_hwrite1),
    .o_hsize  (w_hsize1)
  );

  assign w_next_grant = pick_grant(w_pend0, w_pend1, r_last_grant);
  // Uses the pend value before the completion edge, so a re-request by the
  // just-served master cannot beat a master that was already waiting.
  assign w_other_pend = r_grant ? w_pend0 : w_pend1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pend0 || w_pend1) begin
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_grant;
            r_state      <= ST_ADDR;
          end
        end
        ST_ADDR: r_state <= ST_DATA;
        ST_DATA: begin
          if (s_HREADYOUT) begin
            if (w_other_pend) begin
              r_grant      <= mst_idx_t'(~r_grant);
              r_last_grant <= mst_idx_t'(~r_grant);
              r_state      <= ST_ADDR;
            end else begin
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o = r_grant;
  // Read data is only steered while a transfer is in progress.
  assign w_busy  = (r_state != ST_IDLE);

  always_comb begin
    s_HSEL    = 1'b0;
    s_HADDR   = '0;
    s_HTRANS  = HTRANS_IDLE;
    s_HWRITE  = 1'b0;
    s_HSIZE   = 3'd0;
    s_HWDATA  = '0;
    s_HREADY  = 1'b1;
    m0_HRDATA = '0;
    m1_HRDATA = '0;
    m0_HRESP  = 1'b0;
    m1_HRESP  = 1'b0;

    if (r_state == ST_ADDR) begin
      s_HSEL   = 1'b1;
      s_HTRANS = HTRANS_NONSEQ;
      s_HADDR  = r_grant ? w_haddr1  : w_haddr0;
      s_HWRITE = r_grant ? w_hwrite1 : w_hwrite0;
      s_HSIZE  = r_grant ? w_hsize1  : w_hsize0;
    end

    if (r_state == ST_DATA) begin
      s_HWDATA = r_grant ? m1_HWDATA : m0_HWDATA;
      s_HREADY = s_HREADYOUT;
    end

    if (w_busy && (r_grant == 1'b0)) m0_HRDATA = s_HRDATA;
    if (w_busy && (r_grant == 1'b1)) m1_HRDATA = s_HRDATA;

    if (w_done0) m0_HRESP = s_HRESP;
    if (w_done1) m1_HRESP = s_HRESP;
  end

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_dual_master_arbiter
// Directed bench for ahb_dual_master_arbiter: reset values, single read,
// contended requests, write with wait states, ignored requests, reset
// during a data phase and round-robin alternation.
// ---------------------------------------------------------------------------
module tb_ahb_dual_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK;
  logic          HRESETn;
  logic          m0_HSEL, m1_HSEL;
  logic [AW-1:0] m0_HADDR, m1_HADDR;
  logic [1:0]    m0_HTRANS, m1_HTRANS;
  logic          m0_HWRITE, m1_HWRITE;
  logic [2:0]    m0_HSIZE, m1_HSIZE;
  logic [DW-1:0] m0_HWDATA, m1_HWDATA;
  logic [DW-1:0] m0_HRDATA, m1_HRDATA;
  logic          m0_HREADY, m1_HREADY;
  logic          m0_HRESP, m1_HRESP;
  logic          s_HSEL;
  logic [AW-1:0] s_HADDR;
  logic [1:0]    s_HTRANS;
  logic          s_HWRITE;
  logic [2:0]    s_HSIZE;
  logic [DW-1:0] s_HWDATA;
  logic          s_HREADY;
  logic [DW-1:0] s_HRDATA;
  logic          s_HREADYOUT;
  logic          s_HRESP;
  logic          grant_o;

  int n_vec = 0;
  int n_err = 0;

  ahb_dual_master_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .m0_HSEL     (m0_HSEL),
    .m0_HADDR    (m0_HADDR),
    .m0_HTRANS   (m0_HTRANS),
    .m0_HWRITE   (m0_HWRITE),
    .m0_HSIZE    (m0_HSIZE),
    .m0_HWDATA   (m0_HWDATA),
    .m0_HRDATA   (m0_HRDATA),
    .m0_HREADY   (m0_HREADY),
    .m0_HRESP    (m0_HRESP),
    .m1_HSEL     (m1_HSEL),
    .m1_HADDR    (m1_HADDR),
    .m1_HTRANS   (m1_HTRANS),
    .m1_HWRITE   (m1_HWRITE),
    .m1_HSIZE    (m1_HSIZE),
    .m1_HWDATA   (m1_HWDATA),
    .m1_HRDATA   (m1_HRDATA),
    .m1_HREADY   (m1_HREADY),
    .m1_HRESP    (m1_HRESP),
    .s_HSEL      (s_HSEL),
    .s_HADDR     (s_HADDR),
    .s_HTRANS    (s_HTRANS),
    .s_HWRITE    (s_HWRITE),
    .s_HSIZE     (s_HSIZE),
    .s_HWDATA    (s_HWDATA),
    .s_HREADY    (s_HREADY),
    .s_HRDATA    (s_HRDATA),
    .s_HREADYOUT (s_HREADYOUT),
    .s_HRESP     (s_HRESP),
    .grant_o     (grant_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled well away from the following edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, ".m0_HREADY"}, 32'(m0_HREADY), 32'd1);
    chk({pfx, ".m1_HREADY"}, 32'(m1_HREADY), 32'd1);
    chk({pfx, ".m0_HRESP"},  32'(m0_HRESP),  32'd0);
    chk({pfx, ".m0_HRDATA"}, m0_HRDATA,      32'd0);
    chk({pfx, ".m1_HRDATA"}, m1_HRDATA,      32'd0);
    chk({pfx, ".s_HSEL"},    32'(s_HSEL),    32'd0);
    chk({pfx, ".s_HTRANS"},  32'(s_HTRANS),  32'd0);
    chk({pfx, ".s_HREADY"},  32'(s_HREADY),  32'd1);
    chk({pfx, ".s_HADDR"},   s_HADDR,        32'd0);
    chk({pfx, ".s_HWDATA"},  s_HWDATA,       32'd0);
    chk({pfx, ".grant_o"},   32'(grant_o),   32'd0);
  endtask

  logic [31:0] grants [4];
  int          n_grants;
  int          low_cnt;

  initial begin
    HRESETn     = 1'b0;
    m0_HSEL     = 1'b1;
    m1_HSEL     = 1'b0;
    m0_HADDR    = '0;  m1_HADDR  = '0;
    m0_HTRANS   = 2'b00; m1_HTRANS = 2'b00;
    m0_HWRITE   = 1'b0; m1_HWRITE = 1'b0;
    m0_HSIZE    = 3'd0; m1_HSIZE  = 3'd0;
    m0_HWDATA   = '0;  m1_HWDATA = '0;
    s_HRDATA    = 32'hDEAD_BEEF;
    s_HREADYOUT = 1'b1;
    s_HRESP     = 1'b0;

    // ---- reset values
    tick();
    tick();
    chk_reset_vals("rst");
    HRESETn = 1'b1;
    tick();

    // ---- single M0 read, zero-wait slave
    m0_HTRANS = 2'b10; m0_HADDR = 32'h1C00_0880; m0_HSIZE = 3'd2;
    s_HRDATA  = 32'h1234_5678;
    #1 chk("rd.accept_hready", 32'(m0_HREADY), 32'd1);
    tick();
    m0_HTRANS = 2'b00;
    #1 chk("rd.c1_hready", 32'(m0_HREADY), 32'd0);
    chk("rd.c1_htrans", 32'(s_HTRANS), 32'd0);
    tick();
    chk("rd.c2_htrans", 32'(s_HTRANS), 32'd2);
    chk("rd.c2_hsel",   32'(s_HSEL),   32'd1);
    chk("rd.c2_haddr",  s_HADDR,       32'h1C00_0880);
    chk("rd.c2_hsize",  32'(s_HSIZE),  32'd2);
    chk("rd.c2_grant",  32'(grant_o),  32'd0);
    chk("rd.c2_hready", 32'(m0_HREADY), 32'd0);
    tick();
    chk("rd.c3_hready", 32'(m0_HREADY), 32'd1);
    chk("rd.c3_hrdata", m0_HRDATA,      32'h1234_5678);
    chk("rd.c3_m1rd",   m1_HRDATA,      32'd0);
    chk("rd.c3_htrans", 32'(s_HTRANS),  32'd0);
    tick();
    chk("rd.idle_hrdata", m0_HRDATA, 32'd0);
    chk("rd.idle_htrans", 32'(s_HTRANS), 32'd0);

    // ---- simultaneous requests: M1 wins the tie, M0 stalls 4 cycles
    m0_HTRANS = 2'b10; m0_HADDR = 32'h0000_0A00;
    m1_HSEL   = 1'b1;  m1_HTRANS = 2'b10; m1_HADDR = 32'h0000_0B00;
    tick();
    m0_HTRANS = 2'b00; m1_HTRANS = 2'b00;
    low_cnt = 0;
    #1 chk("tie.c1_m0rdy", 32'(m0_HREADY), 32'd0);
    chk("tie.c1_m1rdy", 32'(m1_HREADY), 32'd0);
    if (!m0_HREADY) low_cnt++;
    tick();
    chk("tie.c2_grant", 32'(grant_o), 32'd1);
    chk("tie.c2_haddr", s_HADDR, 32'h0000_0B00);
    if (!m0_HREADY) low_cnt++;
    tick();
    chk("tie.c3_m1rdy", 32'(m1_HREADY), 32'd1);
    chk("tie.c3_m0rdy", 32'(m0_HREADY), 32'd0);
    if (!m0_HREADY) low_cnt++;
    tick();
    chk("tie.c4_grant", 32'(grant_o), 32'd0);
    chk("tie.c4_haddr", s_HADDR, 32'h0000_0A00);
    if (!m0_HREADY) low_cnt++;
    tick();
    chk("tie.c5_m0rdy", 32'(m0_HREADY), 32'd1);
    chk("tie.m0_low_cycles", 32'(low_cnt), 32'd4);
    tick();

    // ---- M1 write with three slave wait states
    m1_HTRANS = 2'b10; m1_HADDR = 32'h0000_0040; m1_HWRITE = 1'b1; m1_HSIZE = 3'd2;
    tick();
    m1_HTRANS = 2'b00; m1_HWRITE = 1'b0; m1_HWDATA = 32'hA5A5_A5A5;
    s_HREADYOUT = 1'b0;
    tick();
    chk("wr.addr_haddr",  s_HADDR,        32'h0000_0040);
    chk("wr.addr_hwrite", 32'(s_HWRITE),  32'd1);
    chk("wr.addr_hwdata", s_HWDATA,       32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wr.wait%0d_hwdata", i), s_HWDATA, 32'hA5A5_A5A5);
      chk($sformatf("wr.wait%0d_m1rdy", i),  32'(m1_HREADY), 32'd0);
      chk($sformatf("wr.wait%0d_srdy", i),   32'(s_HREADY),  32'd0);
    end
    tick();
    s_HREADYOUT = 1'b1; s_HRESP = 1'b1;
    #1 chk("wr.done_m1rdy",  32'(m1_HREADY), 32'd1);
    chk("wr.done_hwdata", s_HWDATA,        32'hA5A5_A5A5);
    chk("wr.done_srdy",   32'(s_HREADY),   32'd1);
    chk("wr.done_m1resp", 32'(m1_HRESP),   32'd1);
    chk("wr.done_m0resp", 32'(m0_HRESP),   32'd0);
    tick();
    s_HRESP = 1'b0;
    #1 chk("wr.idle_hwdata", s_HWDATA, 32'd0);
    chk("wr.idle_m1resp", 32'(m1_HRESP), 32'd0);

    // ---- BUSY and deselected requests are ignored
    m1_HTRANS = 2'b01; m1_HSEL = 1'b1;
    tick();
    m1_HTRANS = 2'b10; m1_HSEL = 1'b0;
    #1 chk("ign.busy_m1rdy", 32'(m1_HREADY), 32'd1);
    chk("ign.busy_htrans", 32'(s_HTRANS), 32'd0);
    tick();
    m1_HTRANS = 2'b00; m1_HSEL = 1'b1;
    #1 chk("ign.nsel_m1rdy", 32'(m1_HREADY), 32'd1);
    tick();
    chk("ign.nsel_htrans", 32'(s_HTRANS), 32'd0);
    chk("ign.nsel_hsel",   32'(s_HSEL),   32'd0);

    // ---- reset asserted during a stalled data phase
    m0_HTRANS = 2'b10; m0_HADDR = 32'h0000_1000; m0_HWDATA = 32'h5555_AAAA;
    tick();
    m0_HTRANS = 2'b00; s_HREADYOUT = 1'b0;
    tick();
    tick();
    chk("rdat.in_data_m0rdy", 32'(m0_HREADY), 32'd0);
    HRESETn = 1'b0;
    tick();
    chk_reset_vals("rdat");
    HRESETn = 1'b1; s_HREADYOUT = 1'b1;
    tick();
    tick();
    chk("rdat.no_replay_htrans", 32'(s_HTRANS), 32'd0);
    chk("rdat.no_replay_m0rdy",  32'(m0_HREADY), 32'd1);

    // ---- both masters requesting continuously: grants alternate
    m0_HTRANS = 2'b10; m0_HADDR = 32'h0000_0100;
    m1_HTRANS = 2'b10; m1_HADDR = 32'h0000_0200;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      tick();
      if (s_HTRANS == 2'b10) begin
        grants[n_grants] = 32'(grant_o);
        n_grants++;
      end
    end
    m0_HTRANS = 2'b00; m1_HTRANS = 2'b00;
    chk("rr.grants_seen", 32'(n_grants), 32'd4);
    if (n_grants == 4) begin
      chk("rr.grant0", grants[0], 32'd1);
      chk("rr.grant1", grants[1], 32'd0);
      chk("rr.grant2", grants[2], 32'd1);
      chk("rr.grant3", grants[3], 32'd0);
    end
    for (int c = 0; c < 8; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
